// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: bus widths, exec opcodes,
// the MEM FSM state encoding and opcode classification helpers.
package mem_stage_pkg;

  localparam int REG_BUS_W      = 32;
  localparam int EXEC_BUS_W     = 5;
  localparam int REG_ADDR_BUS_W = 5;

  localparam logic [REG_BUS_W-1:0]      ZERO_WORD     = '0;
  localparam logic [EXEC_BUS_W-1:0]     ZERO_EXEC     = '0;
  localparam logic [REG_ADDR_BUS_W-1:0] ZERO_REG_ADDR = '0;

  localparam logic [EXEC_BUS_W-1:0] EXE_NOP = 5'd0;
  localparam logic [EXEC_BUS_W-1:0] EXE_ADD = 5'd1;
  localparam logic [EXEC_BUS_W-1:0] EXE_SUB = 5'd2;
  localparam logic [EXEC_BUS_W-1:0] EXE_AND = 5'd3;
  localparam logic [EXEC_BUS_W-1:0] EXE_OR  = 5'd4;
  localparam logic [EXEC_BUS_W-1:0] EXE_XOR = 5'd5;
  localparam logic [EXEC_BUS_W-1:0] EXE_SLL = 5'd6;
  localparam logic [EXEC_BUS_W-1:0] EXE_SRL = 5'd7;
  localparam logic [EXEC_BUS_W-1:0] EXE_SRA = 5'd8;
  localparam logic [EXEC_BUS_W-1:0] EXE_SLT = 5'd9;
  localparam logic [EXEC_BUS_W-1:0] EXE_LUI = 5'd10;
  localparam logic [EXEC_BUS_W-1:0] EXE_LB  = 5'd16;
  localparam logic [EXEC_BUS_W-1:0] EXE_LH  = 5'd17;
  localparam logic [EXEC_BUS_W-1:0] EXE_LW  = 5'd18;
  localparam logic [EXEC_BUS_W-1:0] EXE_LBU = 5'd19;
  localparam logic [EXEC_BUS_W-1:0] EXE_LHU = 5'd20;
  localparam logic [EXEC_BUS_W-1:0] EXE_SB  = 5'd21;
  localparam logic [EXEC_BUS_W-1:0] EXE_SH  = 5'd22;
  localparam logic [EXEC_BUS_W-1:0] EXE_SW  = 5'd23;

  typedef enum logic {
    MEM_IDLE = 1'b0,
    MEM_XFER = 1'b1
  } mem_state_e;

  function automatic logic is_load(input logic [EXEC_BUS_W-1:0] op);
    return (op == EXE_LB) || (op == EXE_LH) || (op == EXE_LW) ||
           (op == EXE_LBU) || (op == EXE_LHU);
  endfunction

  function automatic logic is_store(input logic [EXEC_BUS_W-1:0] op);
    return (op == EXE_SB) || (op == EXE_SH) || (op == EXE_SW);
  endfunction

  function automatic logic is_mem(input logic [EXEC_BUS_W-1:0] op);
    return is_load(op) || is_store(op);
  endfunction

  // Index of the final byte of an access (byte count minus one).
  function automatic logic [1:0] last_byte_idx(input logic [EXEC_BUS_W-1:0] op);
    logic [1:0] n;
    n = 2'd0;
    if ((op == EXE_LH) || (op == EXE_LHU) || (op == EXE_SH)) n = 2'd1;
    if ((op == EXE_LW) || (op == EXE_SW)) n = 2'd3;
    return n;
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Byte-wide request/acknowledge memory port between the MEM stage
// (master) and the memory (slave).
interface mem_stage_if #(
  parameter int XLEN = 32
);
  logic            mem_req;
  logic            mem_rw;
  logic [XLEN-1:0] mem_addr;
  logic [7:0]      mem_wbyte;
  logic [7:0]      mem_rbyte;
  logic            mem_ack;

  modport master (
    output mem_req, mem_rw, mem_addr, mem_wbyte,
    input  mem_rbyte, mem_ack
  );

  modport slave (
    input  mem_req, mem_rw, mem_addr, mem_wbyte,
    output mem_rbyte, mem_ack
  );
endinterface

// File: rtl/mem_load_extend.sv
// Combinational load formatter: picks the low 1/2/4 byte lanes of an
// assembled little-endian word and sign- or zero-extends to XLEN.
module mem_load_extend
  import mem_stage_pkg::*;
#(
  parameter int XLEN = REG_BUS_W
) (
  input  logic [EXEC_BUS_W-1:0] i_op,
  input  logic [3:0][7:0]       i_lanes,
  output logic [XLEN-1:0]       o_data
);

  always_comb begin
    o_data = '0;
    case (i_op)
      EXE_LB:  o_data = {{(XLEN-8){i_lanes[0][7]}}, i_lanes[0]};
      EXE_LBU: o_data = {{(XLEN-8){1'b0}}, i_lanes[0]};
      EXE_LH:  o_data = {{(XLEN-16){i_lanes[1][7]}}, i_lanes[1], i_lanes[0]};
      EXE_LHU: o_data = {{(XLEN-16){1'b0}}, i_lanes[1], i_lanes[0]};
      EXE_LW:  o_data = XLEN'(i_lanes);
      default: o_data = '0;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Pipeline MEM stage and MEM/WB register: serialises loads/stores over a
// byte-wide req/ack port and stalls upstream until the access completes.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int XLEN = REG_BUS_W,
  parameter int OP_W = EXEC_BUS_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [XLEN-1:0]           ex_alu_in,
  input  logic [XLEN-1:0]           ex_rs2_in,
  input  logic [OP_W-1:0]           ex_exec_in,
  input  logic [REG_ADDR_BUS_W-1:0] ex_rdest_in,
  input  logic                      ex_we_in,
  mem_stage_if.master               mem,
  output logic                      mem_stallreq,
  output logic [XLEN-1:0]           wb_data_out,
  output logic [REG_ADDR_BUS_W-1:0] wb_rdest_out,
  output logic                      wb_we_out
);

  mem_state_e                r_state, w_state_next;
  logic [OP_W-1:0]           r_op, w_op_next;
  logic [XLEN-1:0]           r_rs2, w_rs2_next;
  logic [REG_ADDR_BUS_W-1:0] r_rdest, w_rdest_next;
  logic                      r_we, w_we_next;
  logic [1:0]                r_idx, w_idx_next, w_idx_inc;
  logic [3:0][7:0]           r_lanes, w_lanes_next, w_word;
  logic                      r_req, w_req_next;
  logic                      r_rw, w_rw_next;
  logic [XLEN-1:0]           r_addr, w_addr_next;
  logic [7:0]                r_wbyte, w_wbyte_next;
  logic [XLEN-1:0]           r_wb_data, w_wb_data_next;
  logic [REG_ADDR_BUS_W-1:0] r_wb_rdest, w_wb_rdest_next;
  logic                      r_wb_we, w_wb_we_next;
  logic                      w_in_mem, w_last, w_final;
  logic [XLEN-1:0]           w_load_data;

  assign w_in_mem  = is_mem(ex_exec_in);
  assign w_last    = (r_idx == last_byte_idx(r_op));
  assign w_final   = (r_state == MEM_XFER) && w_last && mem.mem_ack;
  assign w_idx_inc = r_idx + 2'd1;

  // Releasing the stall in the final-ack cycle lets EX advance on the same edge.
  assign mem_stallreq = !rst && w_in_mem && !w_final;

  // The final byte is not registered; it is merged straight from mem_rbyte.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign w_word[gi] = (r_idx == 2'(gi)) ? mem.mem_rbyte : r_lanes[gi];
  end

  mem_load_extend #(.XLEN(XLEN)) u_load_extend (
    .i_op    (r_op),
    .i_lanes (w_word),
    .o_data  (w_load_data)
  );

  always_comb begin
    w_state_next    = r_state;
    w_op_next       = r_op;
    w_rs2_next      = r_rs2;
    w_rdest_next    = r_rdest;
    w_we_next       = r_we;
    w_idx_next      = r_idx;
    w_lanes_next    = r_lanes;
    w_req_next      = r_req;
    w_rw_next       = r_rw;
    w_addr_next     = r_addr;
    w_wbyte_next    = r_wbyte;
    w_wb_data_next  = r_wb_data;
    w_wb_rdest_next = r_wb_rdest;
    w_wb_we_next    = r_wb_we;

    case (r_state)
      MEM_IDLE: begin
        if (w_in_mem) begin
          w_state_next = MEM_XFER;
          w_op_next    = ex_exec_in;
          w_rs2_next   = ex_rs2_in;
          w_rdest_next = ex_rdest_in;
          w_we_next    = ex_we_in;
          w_idx_next   = 2'd0;
          w_req_next   = 1'b1;
          w_rw_next    = is_store(ex_exec_in);
          w_addr_next  = ex_alu_in;
          w_wbyte_next = ex_rs2_in[7:0];
          w_wb_we_next = 1'b0;
        end else begin
          w_wb_data_next  = ex_alu_in;
          w_wb_rdest_next = ex_rdest_in;
          w_wb_we_next    = ex_we_in;
        end
      end
      MEM_XFER: begin
        if (mem.mem_ack) begin
          if (w_last) begin
            w_state_next    = MEM_IDLE;
            w_req_next      = 1'b0;
            w_wb_rdest_next = r_rdest;
            if (is_load(r_op)) begin
              w_wb_data_next = w_load_data;
              w_wb_we_next   = r_we;
            end else begin
              w_wb_data_next = '0;
              w_wb_we_next   = 1'b0;
            end
          end else begin
            if (is_load(r_op)) w_lanes_next[r_idx] = mem.mem_rbyte;
            w_idx_next   = w_idx_inc;
            w_addr_next  = r_addr + XLEN'(1);
            w_wbyte_next = r_rs2[{w_idx_inc, 3'b000} +: 8];
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= MEM_IDLE;
      r_op       <= ZERO_EXEC;
      r_rs2      <= '0;
      r_rdest    <= ZERO_REG_ADDR;
      r_we       <= 1'b0;
      r_idx      <= 2'd0;
      r_lanes    <= '0;
      r_req      <= 1'b0;
      r_rw       <= 1'b0;
      r_addr     <= '0;
      r_wbyte    <= 8'd0;
      r_wb_data  <= '0;
      r_wb_rdest <= ZERO_REG_ADDR;
      r_wb_we    <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_op       <= w_op_next;
      r_rs2      <= w_rs2_next;
      r_rdest    <= w_rdest_next;
      r_we       <= w_we_next;
      r_idx      <= w_idx_next;
      r_lanes    <= w_lanes_next;
      r_req      <= w_req_next;
      r_rw       <= w_rw_next;
      r_addr     <= w_addr_next;
      r_wbyte    <= w_wbyte_next;
      r_wb_data  <= w_wb_data_next;
      r_wb_rdest <= w_wb_rdest_next;
      r_wb_we    <= w_wb_we_next;
    end
  end

  assign mem.mem_req   = r_req;
  assign mem.mem_rw    = r_rw;
  assign mem.mem_addr  = r_addr;
  assign mem.mem_wbyte = r_wbyte;
  assign wb_data_out   = r_wb_data;
  assign wb_rdest_out  = r_wb_rdest;
  assign wb_we_out     = r_wb_we;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: a driver issues EX ops, a memory slave
// with random ack delays checks requests, and a monitor checks write-back.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ex_alu_in, ex_rs2_in;
  logic [4:0]  ex_exec_in, ex_rdest_in;
  logic        ex_we_in;
  logic        mem_stallreq;
  logic [31:0] wb_data_out;
  logic [4:0]  wb_rdest_out;
  logic        wb_we_out;

  always #5 clk = ~clk;

  mem_stage_if #(.XLEN(32)) mem_bus ();

  mem_stage #(.XLEN(32), .OP_W(5)) dut (
    .clk          (clk),
    .rst          (rst),
    .ex_alu_in    (ex_alu_in),
    .ex_rs2_in    (ex_rs2_in),
    .ex_exec_in   (ex_exec_in),
    .ex_rdest_in  (ex_rdest_in),
    .ex_we_in     (ex_we_in),
    .mem          (mem_bus),
    .mem_stallreq (mem_stallreq),
    .wb_data_out  (wb_data_out),
    .wb_rdest_out (wb_rdest_out),
    .wb_we_out    (wb_we_out)
  );

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rdest;
    logic        we;
    bit          chk_rdest;
  } wb_exp_t;

  typedef struct {
    logic [31:0] addr;
    logic        rw;
    logic [7:0]  wbyte;
  } req_exp_t;

  wb_exp_t  wb_q[$];
  req_exp_t req_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  bit op_valid = 1'b0;
  int op_id = 0;
  int fixed_delay = 0;
  int planned_total = 0;
  int ack_count = 0;

  logic [7:0] env_mem [logic [31:0]];
  logic [7:0] ref_mem [logic [31:0]];

  logic [4:0] alu_ops [5] = '{EXE_ADD, EXE_SUB, EXE_XOR, EXE_NOP, EXE_LUI};
  logic [4:0] ld_ops  [5] = '{EXE_LB, EXE_LH, EXE_LW, EXE_LBU, EXE_LHU};
  logic [4:0] st_ops  [3] = '{EXE_SB, EXE_SH, EXE_SW};

  function automatic logic [7:0] dflt_byte(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] env_rd(input logic [31:0] a);
    return env_mem.exists(a) ? env_mem[a] : dflt_byte(a);
  endfunction

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt_byte(a);
  endfunction

  function automatic int nbytes(input logic [4:0] op);
    case (op)
      EXE_LB, EXE_LBU, EXE_SB: return 1;
      EXE_LH, EXE_LHU, EXE_SH: return 2;
      EXE_LW, EXE_SW:          return 4;
      default:                 return 0;
    endcase
  endfunction

  function automatic bit op_is_store(input logic [4:0] op);
    return (op == EXE_SB) || (op == EXE_SH) || (op == EXE_SW);
  endfunction

  task automatic summary();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic poke(input logic [31:0] a, input logic [7:0] b);
    env_mem[a] = b;
    ref_mem[a] = b;
  endtask

  task automatic idle_inputs();
    op_valid    = 1'b0;
    ex_exec_in  = EXE_NOP;
    ex_alu_in   = 32'd0;
    ex_rs2_in   = 32'd0;
    ex_rdest_in = 5'd0;
    ex_we_in    = 1'b0;
  endtask

  // Called just after a rising edge; returns just after the edge where EX advances.
  task automatic run_op(input logic [4:0] op, input logic [31:0] alu, input logic [31:0] rs2,
                        input logic [4:0] rd, input logic we);
    int n, p0, cycles, exp_cycles, v;
    bit stalled;
    logic [31:0] w;
    wb_exp_t e;
    req_exp_t r;
    n = nbytes(op);
    for (int i = 0; i < n; i++) begin
      r.addr  = alu + 32'(i);
      r.rw    = op_is_store(op);
      r.wbyte = rs2[8*i +: 8];
      req_q.push_back(r);
    end
    e.rdest = rd;
    e.we = we;
    e.chk_rdest = 1'b1;
    e.data = alu;
    if (n > 0 && op_is_store(op)) begin
      for (int i = 0; i < n; i++) ref_mem[alu + 32'(i)] = rs2[8*i +: 8];
      e.data = 32'd0;
      e.we = 1'b0;
      e.chk_rdest = 1'b0;
    end else if (n > 0) begin
      w = 32'd0;
      for (int i = 0; i < n; i++) w[8*i +: 8] = ref_rd(alu + 32'(i));
      case (op)
        EXE_LB:  begin v = int'(w[7:0]);  if (v >= 128)   v -= 256;   e.data = 32'(v); end
        EXE_LH:  begin v = int'(w[15:0]); if (v >= 32768) v -= 65536; e.data = 32'(v); end
        EXE_LBU: e.data = {24'd0, w[7:0]};
        EXE_LHU: e.data = {16'd0, w[15:0]};
        default: e.data = w;
      endcase
    end
    wb_q.push_back(e);

    ex_exec_in = op; ex_alu_in = alu; ex_rs2_in = rs2; ex_rdest_in = rd; ex_we_in = we;
    op_valid = 1'b1;
    op_id++;
    p0 = planned_total;
    cycles = 0;
    do begin
      @(negedge clk); #2;
      stalled = mem_stallreq;
      cycles++;
      @(posedge clk); #1;
    end while (stalled && cycles < 300);
    if (stalled) begin
      n_cmp++; n_bad++;
      $display("FAIL stall_timeout: op %0d still stalled after %0d cycles, expected release", op, cycles);
      summary();
      $finish;
    end
    exp_cycles = (n > 0) ? 1 + (planned_total - p0) : 1;
    check("occupancy", 32'(cycles), 32'(exp_cycles));
    $display("op=%0d addr=%08h rs2=%08h rd=%0d we=%0d exp_wb=%08h cycles=%0d",
             op, alu, rs2, rd, we, e.data, cycles);
    idle_inputs();
  endtask

  // Memory slave: random or fixed ack delay per byte, checks each request cycle.
  initial begin
    bit active;
    int cnt;
    active = 1'b0;
    cnt = 0;
    mem_bus.mem_ack = 1'b0;
    mem_bus.mem_rbyte = 8'd0;
    forever begin
      @(negedge clk);
      if (rst || !mem_bus.mem_req) begin
        mem_bus.mem_ack = 1'b0;
        active = 1'b0;
      end else begin
        if (!active) begin
          active = 1'b1;
          cnt = (fixed_delay < 0) ? int'($urandom_range(0, 3)) : fixed_delay;
          planned_total += cnt + 1;
        end
        if (req_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_req: addr 0x%08h, expected no request", mem_bus.mem_addr);
        end else begin
          check("req_addr", mem_bus.mem_addr, req_q[0].addr);
          check("req_rw", 32'(mem_bus.mem_rw), 32'(req_q[0].rw));
          check("req_wbyte", 32'(mem_bus.mem_wbyte), 32'(req_q[0].wbyte));
        end
        if (cnt == 0) begin
          mem_bus.mem_ack = 1'b1;
          mem_bus.mem_rbyte = env_rd(mem_bus.mem_addr);
          if (mem_bus.mem_rw) env_mem[mem_bus.mem_addr] = mem_bus.mem_wbyte;
          if (req_q.size() != 0) void'(req_q.pop_front());
          ack_count++;
          active = 1'b0;
        end else begin
          mem_bus.mem_ack = 1'b0;
          mem_bus.mem_rbyte = 8'($urandom);
          cnt--;
        end
      end
    end
  end

  // Write-back monitor: checks wb_* the cycle after EX advances, and the bubble.
  initial begin
    bit pend, bubble;
    int last_id;
    wb_exp_t e;
    pend = 1'b0;
    bubble = 1'b0;
    last_id = 0;
    forever begin
      @(negedge clk); #2;
      if (pend) begin
        if (wb_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL wb_unexpected: data 0x%08h, expected nothing queued", wb_data_out);
        end else begin
          e = wb_q.pop_front();
          check("wb_data", wb_data_out, e.data);
          check("wb_we", 32'(wb_we_out), 32'(e.we));
          if (e.chk_rdest) check("wb_rdest", 32'(wb_rdest_out), 32'(e.rdest));
        end
      end
      if (bubble) check("bubble_we", 32'(wb_we_out), 32'd0);
      pend = 1'b0;
      bubble = 1'b0;
      if (!rst && op_valid) begin
        if (!mem_stallreq) pend = 1'b1;
        else if (op_id != last_id) bubble = 1'b1;
        last_id = op_id;
      end
    end
  end

  initial begin
    #300000;
    n_cmp++; n_bad++;
    $display("FAIL global_timeout: simulation still running, expected completion");
    summary();
    $finish;
  end

  initial begin
    int base, guard;
    idle_inputs();
    // Reset with a load presented: stall must stay low while rst is high.
    rst = 1'b1;
    ex_exec_in = EXE_LW;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk); #2;
    check("rst_stallreq", 32'(mem_stallreq), 32'd0);
    check("rst_mem_req", 32'(mem_bus.mem_req), 32'd0);
    check("rst_mem_addr", mem_bus.mem_addr, 32'd0);
    check("rst_wb_data", wb_data_out, 32'd0);
    check("rst_wb_we", 32'(wb_we_out), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle_inputs();

    run_op(EXE_ADD, 32'h0000_1234, 32'd0, 5'd5, 1'b1);
    fixed_delay = 0;
    run_op(EXE_SW, 32'h0000_0100, 32'hDEAD_BEEF, 5'd7, 1'b1);
    poke(32'h0000_0203, 8'h80);
    fixed_delay = 3;
    run_op(EXE_LB, 32'h0000_0203, 32'd0, 5'd3, 1'b1);
    run_op(EXE_LBU, 32'h0000_0203, 32'd0, 5'd4, 1'b1);
    fixed_delay = 0;
    poke(32'h0000_03FF, 8'h34);
    poke(32'h0000_0400, 8'h12);
    run_op(EXE_LH, 32'h0000_03FF, 32'd0, 5'd9, 1'b1);
    run_op(EXE_LW, 32'hFFFF_FFFE, 32'd0, 5'd10, 1'b1);
    run_op(EXE_LW, 32'h0000_0100, 32'd0, 5'd11, 1'b1);

    // Reset after the second byte of a load word.
    run_op(EXE_OR, 32'h00C0_FFEE, 32'd0, 5'd12, 1'b1);
    fixed_delay = 0;
    for (int i = 0; i < 4; i++) begin
      req_exp_t r;
      r.addr = 32'h0000_0500 + 32'(i);
      r.rw = 1'b0;
      r.wbyte = 8'h00;
      req_q.push_back(r);
    end
    ex_exec_in = EXE_LW; ex_alu_in = 32'h0000_0500; ex_rs2_in = 32'd0;
    ex_rdest_in = 5'd13; ex_we_in = 1'b1;
    op_valid = 1'b1;
    op_id++;
    base = ack_count;
    guard = 0;
    while (ack_count < base + 2 && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    check("reset_setup_acks", 32'(ack_count - base), 32'd2);
    rst = 1'b1;
    op_valid = 1'b0;
    @(negedge clk); #2;
    check("rst_hi_stallreq", 32'(mem_stallreq), 32'd0);
    @(posedge clk); #1;
    @(negedge clk); #2;
    check("abort_mem_req", 32'(mem_bus.mem_req), 32'd0);
    check("abort_stallreq", 32'(mem_stallreq), 32'd0);
    check("abort_wb_data", wb_data_out, 32'd0);
    check("abort_wb_rdest", 32'(wb_rdest_out), 32'd0);
    check("abort_wb_we", 32'(wb_we_out), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    req_q.delete();
    idle_inputs();
    run_op(EXE_ADD, 32'h0000_0042, 32'd0, 5'd14, 1'b1);

    // Randomized mix of ALU, load and store ops around two address windows.
    fixed_delay = -1;
    for (int k = 0; k < 60; k++) begin
      logic [4:0]  op;
      logic [31:0] a;
      int cls;
      cls = int'($urandom_range(0, 2));
      if (cls == 0) op = alu_ops[$urandom_range(0, 4)];
      else if (cls == 1) op = ld_ops[$urandom_range(0, 4)];
      else op = st_ops[$urandom_range(0, 2)];
      if (cls == 0) a = $urandom;
      else if ($urandom_range(0, 3) == 0) a = 32'hFFFF_FFF8 + 32'($urandom_range(0, 15));
      else a = 32'h0000_0800 + 32'($urandom_range(0, 15));
      run_op(op, a, $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
    end

    repeat (3) @(posedge clk);
    #1;
    check("wb_queue_drained", 32'(wb_q.size()), 32'd0);
    check("req_queue_drained", 32'(req_q.size()), 32'd0);
    summary();
    $finish;
  end

endmodule
